runner_score_timer: RTL and testbench
=====================================

# runner_score_timer

Downstream consumer of the 100 ms tick produced by the millisecond divider chain in the Runner game. It brings the slow tick into the system clock domain and detects its rising edges. It counts elapsed run time as a 4-digit BCD value with 0.1 s resolution (000.0–999.9 s), sequences idle/run/over game phases and keeps a best-time record. Its BCD outputs feed the seven-segment and score display logic.

## Interface
- SYNC_STAGES, 2, synchronizer depth for tick_100ms (legal ≥ 2)
- clk  in  1  system clock (e.g. 100 MHz)
- reset  in  1  asynchronous, active-low; all state cleared while low
- tick_100ms  in  1  level from the 100 ms divider; high for one 1 ms period per 100 ms; asynchronous to clk
- start  in  1  level, sampled each clk; begins a new run
- crash  in  1  level, sampled each clk; ends the current run
- clear  in  1  level, sampled each clk; abort to idle, time zeroed
- time_bcd  out  16  current time, digits [15:12]=hundreds s … [3:0]=tenths
- best_bcd  out  16  best completed run time
- running  out  1  high in RUN
- game_over  out  1  high in OVER
- new_record  out  1  one-cycle pulse when best_bcd is updated
- saturated  out  1  high once time_bcd has reached 9999 in the current run

## Operation
- Tick path: tick_100ms → SYNC_STAGES-flop chain → one more flop (prev); tick_evt = sync_out & ~prev. One tick_evt per tick_100ms rising edge, regardless of its high width.
- FSM states: IDLE, RUN, OVER. Reset → IDLE.
- Priority when several events occur in one cycle: clear > crash > start > tick_evt. The lower-priority events in that cycle are dropped, not deferred.
- clear (any state): → IDLE, time_bcd=0, saturated=0. best_bcd is retained.
- IDLE: start → RUN, time_bcd=0, saturated=0. tick_evt is ignored.
- RUN: tick_evt → time_bcd increments by 1 in BCD. A tenths digit of 9 wraps to 0 with carry into the next digit, and the carry ripples through all four digits. At 9999 the count holds and saturated=1. crash → OVER, time_bcd frozen. start is ignored.
- Entry into OVER: if time_bcd > best_bcd (unsigned compare; BCD ordering equals binary ordering), best_bcd ← time_bcd and new_record=1 for exactly one cycle. Equal or less leaves best_bcd unchanged and gives no pulse.
- OVER: start → RUN with time_bcd=0 and saturated=0. crash and tick_evt are ignored.
- running = (state==RUN); game_over = (state==OVER); both registered.
- No digit ever holds a value above 9.

## Timing
- Reset values: time_bcd=0, best_bcd=0, running=0, game_over=0, new_record=0, saturated=0, all sync/prev flops=0, state IDLE.
- Reset deassertion is not synchronized in this block; the top level supplies a reset that releases synchronously with clk.
- Tick latency: tick_100ms first sampled high at clk edge k → time_bcd shows the new value after edge k+SYNC_STAGES.
- Minimum tick_100ms high and low widths: SYNC_STAGES+1 clk cycles each. The 1 ms period satisfies this with wide margin.
- start, crash or clear asserted at edge k → state, running/game_over and time_bcd reflect it after edge k. new_record is high in the cycle after edge k only.
- Levels held across many cycles act as repeated requests. Example: start held through a crash re-enters RUN one cycle after OVER, which is legal.
- Asynchronous reset mid-run: all outputs go to their reset values immediately, including best_bcd.

## Test plan
- Reset then start, apply 25 tick_100ms pulses (1 ms high, 99 ms low) → time_bcd=0x0025, running=1, exactly 25 increments, each SYNC_STAGES cycles after its tick is sampled.
- Preload count via 99 ticks to 0x0099, apply 1 tick → 0x0100. Run to 0x9998, apply 3 ticks → 0x9999 held, saturated=1.
- Run to 0x0042, crash → game_over=1, best_bcd=0x0042, new_record high for one cycle. Start, run to 0x0030, crash → best_bcd stays 0x0042, no pulse. Repeat at exactly 0x0042 → no pulse.
- Same-cycle events: crash and tick_evt together at 0x0010 → frozen at 0x0010. clear and crash together → IDLE, time_bcd=0, best unchanged. Start and tick_evt in IDLE → RUN at 0x0000.
- Ticks while IDLE and while OVER → time_bcd unchanged. Tick held high for 500 cycles → one increment only.
- Assert reset low in RUN at 0x0123 with best 0x0200 → every output reads 0 at once. After release, state is IDLE.

Source files
------------

// File: rtl/runner_score_timer.sv
// runner_score_timer: synchronises the 100 ms tick, counts run time in 4-digit BCD,
// sequences idle/run/over phases and tracks the best completed run.
module runner_score_timer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick_100ms,
   input  logic        start,
   input  logic        crash,
   input  logic        clear,
   output logic [15:0] time_bcd,
   output logic [15:0] best_bcd,
   output logic        running,
   output logic        game_over,
   output logic        new_record,
   output logic        saturated
);
   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
   state_t state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic prev, tick_evt, carry, sat_nxt, rec_nxt;
   logic [15:0] time_inc, time_nxt, best_nxt;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], tick_100ms};
         prev <= sync[SYNC_STAGES-1];
      end
   assign tick_evt = sync[SYNC_STAGES-1] & ~prev;
   // ripple BCD increment: a digit advances only while every lower digit is 9
   always_comb begin
      time_inc = time_bcd;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         time_inc[4*i+:4] = !carry ? time_bcd[4*i+:4] :
                            (time_bcd[4*i+:4] == 4'd9) ? 4'd0 : time_bcd[4*i+:4] + 4'd1;
         carry = carry & (time_bcd[4*i+:4] == 4'd9);
      end
   end
   always_comb begin
      state_nxt = state;
      time_nxt  = time_bcd;
      best_nxt  = best_bcd;
      sat_nxt   = saturated;
      rec_nxt   = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
         time_nxt  = '0;
         sat_nxt   = 1'b0;
      end else if (state == RUN && crash) begin
         state_nxt = OVER;
         if (time_bcd > best_bcd) begin
            best_nxt = time_bcd;
            rec_nxt  = 1'b1;
         end
      end else if (state != RUN && start) begin
         state_nxt = RUN;
         time_nxt  = '0;
         sat_nxt   = 1'b0;
      end else if (state == RUN && tick_evt && time_bcd != 16'h9999) begin
         time_nxt = time_inc;
         sat_nxt  = time_inc == 16'h9999;
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         time_bcd   <= '0;
         best_bcd   <= '0;
         saturated  <= 1'b0;
         new_record <= 1'b0;
         running    <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state      <= state_nxt;
         time_bcd   <= time_nxt;
         best_bcd   <= best_nxt;
         saturated  <= sat_nxt;
         new_record <= rec_nxt;
         running    <= state_nxt == RUN;
         game_over  <= state_nxt == OVER;
      end
endmodule

// File: tb/tb_runner_score_timer.sv
// tb_runner_score_timer: decimal-count game model checked every cycle, plus directed literal checks.
module tb_runner_score_timer;
   localparam int S = 2;
   localparam int HI = S + 1;
   localparam int LO = S + 1;
   logic clk = 1'b0, reset = 1'b0, tick_100ms = 1'b0, start = 1'b0, crash = 1'b0, clear = 1'b0;
   logic [15:0] time_bcd, best_bcd;
   logic running, game_over, new_record, saturated;
   int checks = 0, failures = 0;
   int m_time = 0, m_best = 0, m_state = 0;
   bit m_nr = 0, m_sat = 0;
   bit smp [S+1];
   always #5 clk = ~clk;
   runner_score_timer #(.SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .tick_100ms(tick_100ms), .start(start), .crash(crash),
      .clear(clear), .time_bcd(time_bcd), .best_bcd(best_bcd), .running(running),
      .game_over(game_over), .new_record(new_record), .saturated(saturated)
   );
   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction
   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask
   // model: state 0=idle 1=run 2=over; a tick rise seen S edges ago advances the count
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_time = 0; m_best = 0; m_state = 0; m_nr = 0; m_sat = 0;
         foreach (smp[i]) smp[i] = 0;
      end else begin
         bit evt;
         evt = smp[S-1] & ~smp[S];
         for (int i = S; i > 0; i--) smp[i] = smp[i-1];
         smp[0] = tick_100ms;
         m_nr = 0;
         if (clear) begin
            m_state = 0; m_time = 0; m_sat = 0;
         end else if (m_state == 1 && crash) begin
            m_state = 2;
            if (m_time > m_best) begin m_best = m_time; m_nr = 1; end
         end else if (m_state != 1 && start) begin
            m_state = 1; m_time = 0; m_sat = 0;
         end else if (m_state == 1 && evt) begin
            if (m_time < 9999) m_time++;
            if (m_time == 9999) m_sat = 1;
         end
      end
   end
   always @(negedge clk) begin
      chk("m_time", time_bcd, to_bcd(m_time));
      chk("m_best", best_bcd, to_bcd(m_best));
      chk("m_running", 16'(running), 16'(m_state == 1));
      chk("m_game_over", 16'(game_over), 16'(m_state == 2));
      chk("m_new_record", 16'(new_record), 16'(m_nr));
      chk("m_saturated", 16'(saturated), 16'(m_sat));
   end
   task automatic ticks(int n);
      repeat (n) begin
         tick_100ms = 1'b1;
         repeat (HI) @(negedge clk);
         tick_100ms = 1'b0;
         repeat (LO) @(negedge clk);
      end
   endtask
   task automatic do_start();
      start = 1'b1; @(negedge clk); start = 1'b0;
   endtask
   task automatic do_crash();
      crash = 1'b1; @(negedge clk); crash = 1'b0;
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_time", time_bcd, 16'h0000);
      chk("rst_best", best_bcd, 16'h0000);
      chk("rst_flags", {12'd0, running, game_over, new_record, saturated}, 16'h0000);
      reset = 1'b1;
      @(negedge clk);
      do_start();
      chk("start_run", 16'(running), 16'h0001);
      ticks(25);
      chk("t25", time_bcd, 16'h0025);
      ticks(17);
      do_crash();
      chk("rec_pulse", 16'(new_record), 16'h0001);
      chk("rec_best", best_bcd, 16'h0042);
      chk("rec_over", 16'(game_over), 16'h0001);
      @(negedge clk);
      chk("rec_pulse_end", 16'(new_record), 16'h0000);
      ticks(2);
      chk("over_ticks", time_bcd, 16'h0042);
      do_start();
      ticks(30);
      do_crash();
      chk("less_nr", 16'(new_record), 16'h0000);
      chk("less_best", best_bcd, 16'h0042);
      do_start();
      ticks(42);
      do_crash();
      chk("eq_nr", 16'(new_record), 16'h0000);
      chk("eq_best", best_bcd, 16'h0042);
      do_start();
      ticks(10);
      tick_100ms = 1'b1;
      repeat (2) @(negedge clk);
      do_crash();
      tick_100ms = 1'b0;
      repeat (LO) @(negedge clk);
      chk("crash_tick", time_bcd, 16'h0010);
      do_start();
      ticks(5);
      clear = 1'b1; crash = 1'b1;
      @(negedge clk);
      clear = 1'b0; crash = 1'b0;
      chk("clr_time", time_bcd, 16'h0000);
      chk("clr_state", {14'd0, running, game_over}, 16'h0000);
      chk("clr_best", best_bcd, 16'h0042);
      ticks(2);
      chk("idle_ticks", time_bcd, 16'h0000);
      tick_100ms = 1'b1;
      repeat (2) @(negedge clk);
      do_start();
      tick_100ms = 1'b0;
      repeat (LO) @(negedge clk);
      chk("start_tick", time_bcd, 16'h0000);
      chk("start_tick_run", 16'(running), 16'h0001);
      ticks(1);
      chk("after_start_tick", time_bcd, 16'h0001);
      tick_100ms = 1'b1;
      repeat (500) @(negedge clk);
      tick_100ms = 1'b0;
      repeat (LO) @(negedge clk);
      chk("long_high", time_bcd, 16'h0002);
      clear = 1'b1; @(negedge clk); clear = 1'b0;
      do_start();
      ticks(200);
      do_crash();
      chk("best200", best_bcd, 16'h0200);
      do_start();
      ticks(123);
      chk("t123", time_bcd, 16'h0123);
      #2 reset = 1'b0;
      #1;
      chk("arst_time", time_bcd, 16'h0000);
      chk("arst_best", best_bcd, 16'h0000);
      chk("arst_flags", {12'd0, running, game_over, new_record, saturated}, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", {14'd0, running, game_over}, 16'h0000);
      ticks(1);
      chk("post_rst_tick", time_bcd, 16'h0000);
      do_start();
      ticks(99);
      chk("t99", time_bcd, 16'h0099);
      ticks(1);
      chk("t100", time_bcd, 16'h0100);
      ticks(9898);
      chk("t9998", time_bcd, 16'h9998);
      chk("t9998_sat", 16'(saturated), 16'h0000);
      ticks(3);
      chk("t9999", time_bcd, 16'h9999);
      chk("t9999_sat", 16'(saturated), 16'h0001);
      do_crash();
      chk("best9999", best_bcd, 16'h9999);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
